// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory program loader.
package imem_loader_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
   localparam int unsigned HDR_BYTES = 2;

   typedef enum logic [2:0] {
      HDR_LO,
      HDR_HI,
      DATA,
      RUN,
      ERROR
   } load_state_t;

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction RAM: synchronous write, asynchronous read, no reset.
module imem_array #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader in front of the instruction RAM; holds the CPU in
// reset until the program is in, then serves instructions combinationally from PC.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   input  logic [31:0]   PC,
   output logic [31:0]   Instr,
   output logic          cpu_reset,
   output logic          load_done,
   output logic          load_err,
   output logic [AW:0]   words_loaded
);

   load_state_t   state;
   logic [15:0]   cnt;
   logic [AW:0]   widx;
   logic [1:0]    bsel;
   logic [23:0]   wbuf;

   logic          xfer;
   logic [15:0]   hdr_cnt;
   logic          last_word;
   logic          we;
   logic [31:0]   wdata;
   logic [AW-1:0] ridx;
   logic [31:0]   rdata;
   logic          in_range;
   logic          unused_pc;

   assign rx_ready  = (state == HDR_LO) || (state == HDR_HI) || (state == DATA);
   assign xfer      = rx_valid && rx_ready;
   assign hdr_cnt   = {rx_data, cnt[7:0]};
   assign last_word = (17'(widx) + 17'd1) == {1'b0, cnt};
   assign we        = xfer && (state == DATA) && (bsel == 2'd3);
   assign wdata     = {rx_data, wbuf};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= HDR_LO;
         cnt       <= '0;
         widx      <= '0;
         bsel      <= '0;
         wbuf      <= '0;
         cpu_reset <= 1'b1;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else if (xfer) begin
         case (state)
            HDR_LO: begin
               cnt[7:0] <= rx_data;
               state    <= HDR_HI;
            end
            HDR_HI: begin
               cnt[15:8] <= rx_data;
               if (hdr_cnt == 16'd0) begin
                  state     <= RUN;
                  cpu_reset <= 1'b0;
                  load_done <= 1'b1;
               end else if (17'(hdr_cnt) > 17'(DEPTH)) begin
                  state    <= ERROR;
                  load_err <= 1'b1;
               end else begin
                  state <= DATA;
               end
            end
            DATA: begin
               bsel <= bsel + 2'd1;
               if (bsel != 2'd3) begin
                  wbuf[{bsel, 3'b000} +: 8] <= rx_data;
               end else begin
                  widx <= widx + 1'b1;
                  if (last_word) begin
                     state     <= RUN;
                     cpu_reset <= 1'b0;
                     load_done <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (widx[AW-1:0]),
      .wdata (wdata),
      .raddr (ridx),
      .rdata (rdata)
   );

   // Stale RAM contents from an earlier load are hidden by the index < cnt check.
   assign ridx      = PC[AW+1:2];
   assign in_range  = (PC[31:AW+2] == '0) && (17'(ridx) < {1'b0, cnt});
   assign Instr     = ((state == RUN) && in_range) ? rdata : NOP_INSTR;
   assign unused_pc = &{1'b0, PC[1:0]};

   assign words_loaded = widx;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, stalls, empty, oversize, reset mid-load, address range.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [31:0] PC = 32'h0;
   logic [31:0] Instr;
   logic        cpu_reset;
   logic        load_done;
   logic        load_err;
   logic [6:0]  words_loaded;

   int unsigned tests_run = 0;
   int unsigned tests_failed = 0;
   int unsigned xfers = 0;
   logic [7:0]  prog[$];

   localparam logic [31:0] NOP = 32'h0000_0013;

   imem_loader #(.DEPTH(64)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .PC           (PC),
      .Instr        (Instr),
      .cpu_reset    (cpu_reset),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset && rx_valid && rx_ready) xfers++;
   end

   task automatic do_reset();
      @(negedge clk);
      rx_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      int unsigned waited = 0;
      @(negedge clk);
      repeat (gap) begin
         rx_valid = 1'b0;
         @(negedge clk);
      end
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!rx_ready) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_byte_timeout: rx_ready=0 required 1");
         rx_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      PC = 32'h0;
      #1;
      tests_run++;
      if ({rx_ready, cpu_reset, load_done, load_err} !== 4'b1100) begin
         tests_failed++;
         $display("FAIL reset_flags: got rdy/cr/done/err=%b required 1100",
                  {rx_ready, cpu_reset, load_done, load_err});
      end
      tests_run++;
      if (words_loaded !== 7'd0) begin
         tests_failed++;
         $display("FAIL reset_words: got %0d required 0", words_loaded);
      end
      tests_run++;
      if (Instr !== NOP) begin
         tests_failed++;
         $display("FAIL reset_instr: got %h required %h", Instr, NOP);
      end
   endtask

   task automatic test_basic_load();
      do_reset();
      PC = 32'h0;
      prog = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
      for (int i = 0; i < 9; i++) send_byte(prog[i], 0);
      tests_run++;
      if ({cpu_reset, load_done, words_loaded} !== {2'b10, 7'd1}) begin
         tests_failed++;
         $display("FAIL basic_before_last: got cr=%b done=%b words=%0d required cr=1 done=0 words=1",
                  cpu_reset, load_done, words_loaded);
      end
      send_byte(prog[9], 0);
      tests_run++;
      if ({cpu_reset, load_done, load_err, rx_ready, words_loaded} !== {4'b0100, 7'd2}) begin
         tests_failed++;
         $display("FAIL basic_release: got cr=%b done=%b err=%b rdy=%b words=%0d required 0 1 0 0 words=2",
                  cpu_reset, load_done, load_err, rx_ready, words_loaded);
      end
      tests_run++;
      if (Instr !== 32'h00A00513) begin
         tests_failed++;
         $display("FAIL basic_first_fetch: got %h required 00a00513", Instr);
      end
      PC = 32'h4;
      #1;
      tests_run++;
      if (Instr !== 32'h00B00593) begin
         tests_failed++;
         $display("FAIL basic_pc4: got %h required 00b00593", Instr);
      end
      PC = 32'h8;
      #1;
      tests_run++;
      if (Instr !== NOP) begin
         tests_failed++;
         $display("FAIL basic_pc8: got %h required %h", Instr, NOP);
      end
   endtask

   task automatic test_stalls();
      int unsigned x0;
      do_reset();
      PC = 32'h0;
      x0 = xfers;
      prog = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
      foreach (prog[i]) send_byte(prog[i], $urandom_range(0, 5));
      repeat (3) @(negedge clk);
      tests_run++;
      if (xfers - x0 !== 10) begin
         tests_failed++;
         $display("FAIL stall_xfers: got %0d required 10", xfers - x0);
      end
      tests_run++;
      if ({cpu_reset, load_done, words_loaded} !== {2'b01, 7'd2}) begin
         tests_failed++;
         $display("FAIL stall_release: got cr=%b done=%b words=%0d required cr=0 done=1 words=2",
                  cpu_reset, load_done, words_loaded);
      end
      #1;
      tests_run++;
      if (Instr !== 32'h00A00513) begin
         tests_failed++;
         $display("FAIL stall_pc0: got %h required 00a00513", Instr);
      end
      PC = 32'h4;
      #1;
      tests_run++;
      if (Instr !== 32'h00B00593) begin
         tests_failed++;
         $display("FAIL stall_pc4: got %h required 00b00593", Instr);
      end
   endtask

   task automatic test_empty();
      logic [31:0] pcs [4] = '{32'h0, 32'h4, 32'h8, 32'h100};
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      tests_run++;
      if ({cpu_reset, load_done, load_err, rx_ready, words_loaded} !== {4'b0100, 7'd0}) begin
         tests_failed++;
         $display("FAIL empty_release: got cr=%b done=%b err=%b rdy=%b words=%0d required 0 1 0 0 words=0",
                  cpu_reset, load_done, load_err, rx_ready, words_loaded);
      end
      foreach (pcs[i]) begin
         PC = pcs[i];
         #1;
         tests_run++;
         if (Instr !== NOP) begin
            tests_failed++;
            $display("FAIL empty_instr pc=%h: got %h required %h", pcs[i], Instr, NOP);
         end
      end
   endtask

   task automatic test_oversize();
      int unsigned x0;
      do_reset();
      send_byte(8'h41, 0);
      send_byte(8'h00, 0);
      tests_run++;
      if ({load_err, rx_ready, cpu_reset, load_done} !== 4'b1010) begin
         tests_failed++;
         $display("FAIL oversize_flags: got err/rdy/cr/done=%b required 1010",
                  {load_err, rx_ready, cpu_reset, load_done});
      end
      x0 = xfers;
      @(negedge clk);
      rx_data = 8'h13;
      rx_valid = 1'b1;
      repeat (4) @(negedge clk);
      rx_valid = 1'b0;
      tests_run++;
      if (xfers - x0 !== 0 || words_loaded !== 7'd0 || rx_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL oversize_no_accept: got xfers=%0d words=%0d rdy=%b required 0 0 0",
                  xfers - x0, words_loaded, rx_ready);
      end
      PC = 32'h0;
      #1;
      tests_run++;
      if (Instr !== NOP || cpu_reset !== 1'b1) begin
         tests_failed++;
         $display("FAIL oversize_hold: got instr=%h cr=%b required %h 1", Instr, cpu_reset, NOP);
      end
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      prog = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      foreach (prog[i]) send_byte(prog[i], 0);
      tests_run++;
      if (words_loaded !== 7'd1) begin
         tests_failed++;
         $display("FAIL midload_progress: got %0d required 1", words_loaded);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      tests_run++;
      if ({words_loaded, cpu_reset, load_done, rx_ready} !== {7'd0, 3'b101}) begin
         tests_failed++;
         $display("FAIL midload_async_reset: got words=%0d cr=%b done=%b rdy=%b required 0 1 0 1",
                  words_loaded, cpu_reset, load_done, rx_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      prog = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      foreach (prog[i]) send_byte(prog[i], 0);
      PC = 32'h0;
      #1;
      tests_run++;
      if (words_loaded !== 7'd1 || load_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL midload_reload: got words=%0d done=%b required 1 1", words_loaded, load_done);
      end
      tests_run++;
      if (Instr !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL midload_pc0: got %h required deadbeef", Instr);
      end
      PC = 32'h4;
      #1;
      tests_run++;
      if (Instr !== NOP) begin
         tests_failed++;
         $display("FAIL midload_stale_masked: got %h required %h", Instr, NOP);
      end
   endtask

   task automatic test_address_range();
      logic [31:0] w;
      logic [31:0] pcs [6] = '{32'h0000_0100, 32'h0000_00FE, 32'h0000_00FC,
                               32'h0000_0080, 32'h0000_0001, 32'h4000_0000};
      logic [31:0] exp [6] = '{NOP, 32'hC0DE_003F, 32'hC0DE_003F,
                               32'hC0DE_0020, 32'hC0DE_0000, NOP};
      do_reset();
      send_byte(8'h40, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 64; i++) begin
         w = 32'hC0DE_0000 | 32'(i);
         for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 0);
         if (i == 62) begin
            tests_run++;
            if (words_loaded !== 7'd63 || cpu_reset !== 1'b1) begin
               tests_failed++;
               $display("FAIL full_before_last: got words=%0d cr=%b required 63 1",
                        words_loaded, cpu_reset);
            end
         end
      end
      tests_run++;
      if ({words_loaded, cpu_reset, load_done, load_err} !== {7'd64, 3'b010}) begin
         tests_failed++;
         $display("FAIL full_release: got words=%0d cr=%b done=%b err=%b required 64 0 1 0",
                  words_loaded, cpu_reset, load_done, load_err);
      end
      foreach (pcs[i]) begin
         PC = pcs[i];
         #1;
         tests_run++;
         if (Instr !== exp[i]) begin
            tests_failed++;
            $display("FAIL range_pc=%h: got %h required %h", pcs[i], Instr, exp[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_stalls();
      test_empty();
      test_oversize();
      test_reset_mid_load();
      test_address_range();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
